pipe_flush_ctrl: RTL and testbench

PIPE_FLUSH_CTRL -- requirements
Module: pipe_flush_ctrl

---
 rtl/pipe_flush_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_flush_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_flush_ctrl.sv
// Pipeline flush / stall controller.
// Detects MEM-stage redirects (trap, mret, taken branch/jump) and ID/EX
// load-use hazards, drives PC select, stall, bubble and flush controls, and
// squashes a configurable number of in-flight fetch slots after a redirect.
// A data-memory stall freezes everything and defers any pending redirect.
module pipe_flush_ctrl #(
  parameter int unsigned SQUASH_CYCLES = 1  // fetch slots squashed after a redirect, 0..3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_is_load,
  input  logic       i_mem_is_trap,
  input  logic       i_mem_is_mret,
  input  logic       i_mem_is_branch_jump,
  input  logic       i_dmem_stall,
  input  logic       i_imem_ready,
  output logic [1:0] o_pc_sel,
  output logic       o_pc_stall,
  output logic       o_if_id_stall,
  output logic       o_id_ex_bubble,
  output logic       o_if_id_flush,
  output logic       o_id_ex_flush,
  output logic       o_ex_mem_flush,
  output logic       o_inst_nop,
  output logic       o_squashing
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_t;

  // PC select encodings
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_MEPC   = 2'b10;
  localparam logic [1:0] PC_MTVEC  = 2'b11;

  // Reload value for the squash counter; the parameter range fits in 2 bits.
  localparam logic [1:0] SQUASH_LOAD = SQUASH_CYCLES[1:0];

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_next;

  logic w_redirect;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;

  // A redirect is only taken once MEM can actually retire its instruction.
  assign w_redirect = (i_mem_is_trap | i_mem_is_mret | i_mem_is_branch_jump) & ~i_dmem_stall;

  // Load-use hazard: the ID instruction needs a value the EX load has not produced yet.
  // x0 is never a real dependency.
  assign w_rs1_hit  = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit  = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
  assign w_load_use = i_ex_is_load & (i_ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);

  // State and squash counter register; reset aborts any squash immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic: freeze on dmem stall, (re)start squash on redirect,
  // count down squash slots only when a fetch is actually delivered.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (!i_dmem_stall) begin
      if (w_redirect) begin
        // A second redirect restarts the squash window rather than extending it.
        if (SQUASH_CYCLES != 0) begin
          w_state_next = ST_SQUASH;
          w_cnt_next   = SQUASH_LOAD;
        end else begin
          w_state_next = ST_RUN;
          w_cnt_next   = 2'd0;
        end
      end else if ((r_state == ST_SQUASH) && i_imem_ready) begin
        // Treat cnt of 0 in SQUASH like the last slot so the FSM can never stick.
        if (r_cnt <= 2'd1) begin
          w_state_next = ST_RUN;
          w_cnt_next   = 2'd0;
        end else begin
          w_cnt_next   = r_cnt - 2'd1;
        end
      end
    end
  end

  // Output decode: dmem stall dominates, then redirect (which overrides a
  // load-use hazard), then the single-cycle load-use stall.
  always_comb begin
    o_pc_sel       = PC_SEQ;
    o_pc_stall     = 1'b0;
    o_if_id_stall  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_flush = 1'b0;
    o_inst_nop     = (r_state == ST_SQUASH);
    o_squashing    = (r_state == ST_SQUASH);

    if (i_dmem_stall) begin
      o_pc_stall    = 1'b1;
      o_if_id_stall = 1'b1;
    end else if (w_redirect) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
      o_inst_nop    = 1'b1;
      if (i_mem_is_trap) begin
        o_pc_sel       = PC_MTVEC;
        o_ex_mem_flush = 1'b1;
      end else if (i_mem_is_mret) begin
        o_pc_sel       = PC_MEPC;
        o_ex_mem_flush = 1'b1;
      end else begin
        o_pc_sel       = PC_BRANCH;
      end
    end else if (w_load_use) begin
      o_pc_stall     = 1'b1;
      o_if_id_stall  = 1'b1;
      o_id_ex_bubble = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Directed testbench for pipe_flush_ctrl. Two instances share the inputs:
// one with a single squash slot and one with three, so the squash window
// length and restart behaviour are visible side by side.
// Output vector layout used by every comparison (10 bits):
//   [9:8] pc_sel, [7] pc_stall, [6] if_id_stall, [5] id_ex_bubble,
//   [4] if_id_flush, [3] id_ex_flush, [2] ex_mem_flush, [1] inst_nop, [0] squashing
`timescale 1ns/1ps
module tb_pipe_flush_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_is_load;
  logic       mem_is_trap, mem_is_mret, mem_is_branch_jump;
  logic       dmem_stall, imem_ready;

  logic [1:0] a_pc_sel, b_pc_sel;
  logic       a_pc_stall, a_if_id_stall, a_id_ex_bubble, a_if_id_flush;
  logic       a_id_ex_flush, a_ex_mem_flush, a_inst_nop, a_squashing;
  logic       b_pc_stall, b_if_id_stall, b_id_ex_bubble, b_if_id_flush;
  logic       b_id_ex_flush, b_ex_mem_flush, b_inst_nop, b_squashing;

  logic [9:0] v1, v3;

  int checks_cnt;
  int fail_cnt;

  // Common expected patterns
  localparam logic [9:0] E_IDLE   = 10'b00_000_000_0_0;
  localparam logic [9:0] E_SQ     = 10'b00_000_000_1_1;
  localparam logic [9:0] E_BR     = 10'b01_000_110_1_0;
  localparam logic [9:0] E_BR_SQ  = 10'b01_000_110_1_1;
  localparam logic [9:0] E_LU     = 10'b00_111_000_0_0;
  localparam logic [9:0] E_TRAP   = 10'b11_000_111_1_0;
  localparam logic [9:0] E_MRET   = 10'b10_000_111_1_0;
  localparam logic [9:0] E_DST    = 10'b00_110_000_0_0;
  localparam logic [9:0] E_DST_SQ = 10'b00_110_000_1_1;

  pipe_flush_ctrl #(.SQUASH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
    .i_ex_rd(ex_rd), .i_ex_is_load(ex_is_load),
    .i_mem_is_trap(mem_is_trap), .i_mem_is_mret(mem_is_mret),
    .i_mem_is_branch_jump(mem_is_branch_jump),
    .i_dmem_stall(dmem_stall), .i_imem_ready(imem_ready),
    .o_pc_sel(a_pc_sel), .o_pc_stall(a_pc_stall), .o_if_id_stall(a_if_id_stall),
    .o_id_ex_bubble(a_id_ex_bubble), .o_if_id_flush(a_if_id_flush),
    .o_id_ex_flush(a_id_ex_flush), .o_ex_mem_flush(a_ex_mem_flush),
    .o_inst_nop(a_inst_nop), .o_squashing(a_squashing)
  );

  pipe_flush_ctrl #(.SQUASH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
    .i_ex_rd(ex_rd), .i_ex_is_load(ex_is_load),
    .i_mem_is_trap(mem_is_trap), .i_mem_is_mret(mem_is_mret),
    .i_mem_is_branch_jump(mem_is_branch_jump),
    .i_dmem_stall(dmem_stall), .i_imem_ready(imem_ready),
    .o_pc_sel(b_pc_sel), .o_pc_stall(b_pc_stall), .o_if_id_stall(b_if_id_stall),
    .o_id_ex_bubble(b_id_ex_bubble), .o_if_id_flush(b_if_id_flush),
    .o_id_ex_flush(b_id_ex_flush), .o_ex_mem_flush(b_ex_mem_flush),
    .o_inst_nop(b_inst_nop), .o_squashing(b_squashing)
  );

  assign v1 = {a_pc_sel, a_pc_stall, a_if_id_stall, a_id_ex_bubble, a_if_id_flush,
               a_id_ex_flush, a_ex_mem_flush, a_inst_nop, a_squashing};
  assign v3 = {b_pc_sel, b_pc_stall, b_if_id_stall, b_id_ex_bubble, b_if_id_flush,
               b_id_ex_flush, b_ex_mem_flush, b_inst_nop, b_squashing};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end else begin
      $display("ok   %s got=%b", tag, got);
    end
  endtask

  task automatic clr();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0;
    mem_is_trap = 1'b0; mem_is_mret = 1'b0; mem_is_branch_jump = 1'b0;
    dmem_stall = 1'b0; imem_ready = 1'b0;
  endtask

  // Inputs are applied at a falling edge; check both instances 1ns later,
  // then move on to the next falling edge.
  task automatic cyc(input string tag, input logic [9:0] e1, input logic [9:0] e3);
    #1;
    check({tag, "/sq1"}, v1, e1);
    check({tag, "/sq3"}, v3, e3);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    rst = 1'b1;
    clr();
    #1;
    check("reset/sq1", v1, E_IDLE);
    check("reset/sq3", v3, E_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // Single branch, imem always ready
    clr(); imem_ready = 1'b1; mem_is_branch_jump = 1'b1;
    cyc("br_redirect", E_BR, E_BR);
    clr(); imem_ready = 1'b1;
    cyc("br_slot1", E_SQ, E_SQ);
    cyc("br_slot2", E_IDLE, E_SQ);
    cyc("br_slot3", E_IDLE, E_SQ);
    cyc("br_done", E_IDLE, E_IDLE);

    // Load-use hazards and their non-hazard boundaries
    clr(); ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    cyc("lu_rs2", E_LU, E_LU);
    clr(); ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    cyc("lu_x0", E_IDLE, E_IDLE);
    clr(); ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    cyc("lu_rs1", E_LU, E_LU);
    clr(); ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0;
    cyc("lu_rs1_unused", E_IDLE, E_IDLE);
    clr(); ex_is_load = 1'b0; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
    cyc("lu_not_load", E_IDLE, E_IDLE);

    // Trap + mret + hazard together: trap wins, hazard ignored
    clr(); imem_ready = 1'b1; mem_is_trap = 1'b1; mem_is_mret = 1'b1;
    ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    cyc("trap_mret_lu", E_TRAP, E_TRAP);
    clr(); imem_ready = 1'b1;
    cyc("trap_slot1", E_SQ, E_SQ);
    cyc("trap_slot2", E_IDLE, E_SQ);
    cyc("trap_slot3", E_IDLE, E_SQ);
    cyc("trap_done", E_IDLE, E_IDLE);

    // mret held behind a dmem stall, then acted on when the stall drops
    for (int i = 0; i < 3; i++) begin
      clr(); imem_ready = 1'b1; mem_is_mret = 1'b1; dmem_stall = 1'b1;
      cyc($sformatf("mret_stall%0d", i), E_DST, E_DST);
    end
    clr(); imem_ready = 1'b1; mem_is_mret = 1'b1;
    cyc("mret_release", E_MRET, E_MRET);
    clr(); imem_ready = 1'b1;
    cyc("mret_slot1", E_SQ, E_SQ);
    // dmem stall mid-squash: inst_nop held, counter frozen
    clr(); imem_ready = 1'b1; dmem_stall = 1'b1;
    cyc("sq_dstall", E_DST, E_DST_SQ);
    clr(); imem_ready = 1'b1;
    cyc("mret_slot2", E_IDLE, E_SQ);
    cyc("mret_slot3", E_IDLE, E_SQ);
    cyc("mret_done", E_IDLE, E_IDLE);

    // Gaps in imem_ready and a second branch restarting the squash window
    clr(); imem_ready = 1'b1; mem_is_branch_jump = 1'b1;
    cyc("gap_br1", E_BR, E_BR);
    clr(); imem_ready = 1'b0;
    cyc("gap_a", E_SQ, E_SQ);
    clr(); imem_ready = 1'b1;
    cyc("gap_b", E_SQ, E_SQ);
    clr(); imem_ready = 1'b0; mem_is_branch_jump = 1'b1;
    cyc("gap_br2", E_BR, E_BR_SQ);
    clr(); imem_ready = 1'b1;
    cyc("gap_c", E_SQ, E_SQ);
    clr(); imem_ready = 1'b0;
    cyc("gap_d", E_IDLE, E_SQ);
    clr(); imem_ready = 1'b1;
    cyc("gap_e", E_IDLE, E_SQ);
    clr(); imem_ready = 1'b0;
    cyc("gap_f", E_IDLE, E_SQ);
    clr(); imem_ready = 1'b1;
    cyc("gap_g", E_IDLE, E_SQ);
    clr(); imem_ready = 1'b0;
    cyc("gap_done", E_IDLE, E_IDLE);

    // Asynchronous reset pulse between clock edges aborts the squash
    clr(); imem_ready = 1'b1; mem_is_branch_jump = 1'b1;
    cyc("rst_br", E_BR, E_BR);
    clr();
    #1;
    check("rst_pre/sq3", v3, E_SQ);
    #2 rst = 1'b1;
    #1;
    check("rst_async/sq1", v1, E_IDLE);
    check("rst_async/sq3", v3, E_IDLE);
    #2 rst = 1'b0;
    #1;
    check("rst_release/sq3", v3, E_IDLE);
    @(negedge clk);
    clr();
    cyc("rst_after", E_IDLE, E_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
